// File: rtl/ofdm_preamble_pkg.sv
// OFDM preamble shared definitions: states, lengths and
// 802.11a short/long training tables (Q1.15 per component).
package ofdm_preamble_pkg;

  localparam int STS_LEN    = 16;
  localparam int LTS_GI_LEN = 32;
  localparam int LTS_LEN    = 64;

  typedef enum logic [1:0] {
    IDLE,
    STS,
    LTS_GI,
    LTS_SYM
  } state_t;

  // Tables kept in thousandths so they read like the annex.
  localparam int STS_RE [STS_LEN] = '{
    46, -132, -13, 143, 92, 143, -13, -132,
    46, 2, -79, -13, 0, -13, -79, 2
  };
  localparam int STS_IM [STS_LEN] = '{
    46, 2, -79, -13, 0, -13, -79, 2,
    46, -132, -13, 143, 92, 143, -13, -132
  };
  localparam int LTS_RE [LTS_LEN] = '{
    -156, 12, 92, -92, -3, 75, -127, -122,
    -35, -56, -60, 70, 82, -131, -57, 37,
    62, 119, -22, 59, 24, -137, 1, 53,
    98, -38, -115, 60, 21, 97, 40, -5,
    156, -5, 40, 97, 21, 60, -115, -38,
    98, 53, 1, -137, 24, 59, -22, 119,
    62, 37, -57, -131, 82, 70, -60, -56,
    -35, -122, -127, 75, -3, -92, 92, 12
  };
  localparam int LTS_IM [LTS_LEN] = '{
    0, -98, -106, -115, -54, 74, 21, 17,
    151, 22, -81, -14, -92, -65, -39, -98,
    62, 4, -161, 15, 59, 47, 115, -4,
    26, 106, 55, 88, -28, -83, 111, 120,
    0, -120, -111, 83, 28, -88, -55, -106,
    -26, 4, -115, -47, -59, -15, 161, -4,
    -62, 98, 39, 65, 92, 14, 81, -22,
    -151, -17, -21, -74, 54, 115, 106, 98
  };

  function automatic int clogb2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  // Thousandths to Q1.15, rounded half away from zero.
  function automatic logic [15:0] q15(input int m);
    int t;
    t = (m * 32768 + ((m < 0) ? -500 : 500)) / 1000;
    return 16'(t);
  endfunction

  function automatic logic [31:0] sts_rom(input int i);
    return {q15(STS_RE[i]), q15(STS_IM[i])};
  endfunction

  function automatic logic [31:0] lts_rom(input int i);
    return {q15(LTS_RE[i]), q15(LTS_IM[i])};
  endfunction

endpackage

// File: rtl/preamble_rom.sv
// Training-sequence ROM: STS and LTS tables behind one
// registered read port with read enable and sync clear.
module preamble_rom
  import ofdm_preamble_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        rd_en,
  input  logic        lts_sel,
  input  logic [5:0]  addr,
  output logic [31:0] data
);

  logic [31:0] sts_tab [STS_LEN];
  logic [31:0] lts_tab [LTS_LEN];

  for (genvar i = 0; i < STS_LEN; i++) begin : g_sts
    assign sts_tab[i] = sts_rom(i);
  end

  for (genvar i = 0; i < LTS_LEN; i++) begin : g_lts
    assign lts_tab[i] = lts_rom(i);
  end

  // Registered read; clear wins so aborts present zero.
  always_ff @(posedge clk) begin
    if (clr)
      data <= '0;
    else if (rd_en)
      data <= lts_sel ? lts_tab[addr] : sts_tab[addr[3:0]];
  end

endmodule

// File: rtl/preamble_gen.sv
// 802.11a preamble generator: STS repeats, LTS guard and
// two LTS symbols, streamed on a valid/ready port.
module preamble_gen
  import ofdm_preamble_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int STS_REPEAT = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  start,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  localparam int HALF      = DATA_WIDTH / 2;
  localparam int STS_TOTAL = STS_REPEAT * STS_LEN;
  localparam int SYM_TOTAL = 2 * LTS_LEN;
  localparam int W_STS     = clogb2(STS_TOTAL);
  localparam int W_SYM     = clogb2(SYM_TOTAL);
  // The LTS symbol pair must also fit, so never below 7 bits.
  localparam int CNT_W     = (W_STS > W_SYM) ? W_STS : W_SYM;

  localparam logic [CNT_W-1:0] STS_END = CNT_W'(STS_TOTAL - 1);
  localparam logic [CNT_W-1:0] GI_END  = CNT_W'(LTS_GI_LEN - 1);
  localparam logic [CNT_W-1:0] SYM_END = CNT_W'(SYM_TOTAL - 1);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             xfer;
  logic             clr;
  logic             rd_en;
  logic             lts_sel;
  logic [5:0]       addr;
  logic [31:0]      rom_data;

  assign clr  = rst | ~enable;
  assign xfer = out_valid & out_ready;

  // State and index of the sample currently presented.
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Advance on start or on each transfer; ROM fetches the
  // next position so the output register stays one ahead.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    lts_sel = 1'b0;
    addr    = '0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = STS;
          cnt_n   = '0;
        end
      end
      STS: begin
        if (xfer) begin
          if (cnt == STS_END) begin
            state_n = LTS_GI;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      LTS_GI: begin
        if (xfer) begin
          if (cnt == GI_END) begin
            state_n = LTS_SYM;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      LTS_SYM: begin
        if (xfer) begin
          if (cnt == SYM_END) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
    unique case (state_n)
      STS:     addr = {2'b00, cnt_n[3:0]};
      LTS_GI:  begin
        lts_sel = 1'b1;
        addr    = {1'b1, cnt_n[4:0]};
      end
      LTS_SYM: begin
        lts_sel = 1'b1;
        addr    = cnt_n[5:0];
      end
      default: addr = '0;
    endcase
  end

  assign rd_en = (~out_valid | out_ready) & (state_n != IDLE);

  preamble_rom u_rom (
    .clk     (clk),
    .clr     (clr),
    .rd_en   (rd_en),
    .lts_sel (lts_sel),
    .addr    (addr),
    .data    (rom_data)
  );

  assign out_valid = (state != IDLE);
  assign busy      = out_valid;
  assign out_last  = (state == LTS_SYM) && (cnt == SYM_END);

  // Q1.15 is left-justified into wider lanes, MSBs kept in narrower.
  if (HALF >= 16) begin : g_wide
    assign out_data = {
      HALF'($signed(rom_data[31:16])) << (HALF - 16),
      HALF'($signed(rom_data[15:0]))  << (HALF - 16)
    };
  end else begin : g_narrow
    assign out_data = {rom_data[31 -: HALF], rom_data[15 -: HALF]};
  end

endmodule

// File: tb/tb_preamble_gen.sv
// Bench for preamble_gen: random backpressure against a
// frame-level reference built from the annex tables.
module tb_preamble_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, enable, start, sel, out_ready;
  logic start_a, start_b;
  logic busy_a, valid_a, last_a;
  logic busy_b, valid_b, last_b;
  logic [31:0] data_a, data_b;
  logic obs_v, obs_b, obs_l;
  logic [31:0] obs_d;

  assign start_a = start & ~sel;
  assign start_b = start & sel;
  assign obs_v = sel ? valid_b : valid_a;
  assign obs_b = sel ? busy_b  : busy_a;
  assign obs_l = sel ? last_b  : last_a;
  assign obs_d = sel ? data_b  : data_a;

  preamble_gen #(.DATA_WIDTH(32), .STS_REPEAT(10)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .start(start_a),
    .busy(busy_a), .out_valid(valid_a), .out_ready(out_ready),
    .out_data(data_a), .out_last(last_a)
  );

  preamble_gen #(.DATA_WIDTH(32), .STS_REPEAT(2)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .start(start_b),
    .busy(busy_b), .out_valid(valid_b), .out_ready(out_ready),
    .out_data(data_b), .out_last(last_b)
  );

  int vectors = 0;
  int errors  = 0;

  int sts_re [16] = '{46, -132, -13, 143, 92, 143, -13, -132,
                      46, 2, -79, -13, 0, -13, -79, 2};
  int sts_im [16] = '{46, 2, -79, -13, 0, -13, -79, 2,
                      46, -132, -13, 143, 92, 143, -13, -132};
  int lts_re [64] = '{
    -156, 12, 92, -92, -3, 75, -127, -122, -35, -56, -60, 70, 82, -131, -57, 37,
    62, 119, -22, 59, 24, -137, 1, 53, 98, -38, -115, 60, 21, 97, 40, -5,
    156, -5, 40, 97, 21, 60, -115, -38, 98, 53, 1, -137, 24, 59, -22, 119,
    62, 37, -57, -131, 82, 70, -60, -56, -35, -122, -127, 75, -3, -92, 92, 12};
  int lts_im [64] = '{
    0, -98, -106, -115, -54, 74, 21, 17, 151, 22, -81, -14, -92, -65, -39, -98,
    62, 4, -161, 15, 59, 47, 115, -4, 26, 106, 55, 88, -28, -83, 111, 120,
    0, -120, -111, 83, 28, -88, -55, -106, -26, 4, -115, -47, -59, -15, 161, -4,
    -62, 98, 39, 65, 92, 14, 81, -22, -151, -17, -21, -74, 54, 115, 106, 98};

  function automatic logic [15:0] to_q15(input int m);
    real x;
    x = m * 32.768;
    return 16'(int'(x));
  endfunction

  // Sample n of a frame with rep short periods.
  function automatic logic [31:0] ref_sample(input int n, input int rep);
    int sl, re, im;
    sl = rep * 16;
    if (n < sl) begin
      re = sts_re[n % 16];
      im = sts_im[n % 16];
    end else if (n < sl + 32) begin
      re = lts_re[n - sl + 32];
      im = lts_im[n - sl + 32];
    end else begin
      re = lts_re[(n - sl - 32) % 64];
      im = lts_im[(n - sl - 32) % 64];
    end
    return {to_q15(re), to_q15(im)};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Start a frame and follow it until stop_at transfers or its end.
  task automatic stream(input int rep, input int pct, input int stop_at,
                        input int s1, input int s2,
                        output int got, output int cycles, output int lasts);
    int total;
    logic [31:0] pd;
    logic pl, stall;
    total = rep * 16 + 160;
    got = 0; cycles = 0; lasts = 0;
    stall = 1'b0; pd = '0; pl = 1'b0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    vectors++;
    if (obs_v !== 1'b1 || obs_b !== 1'b1) begin
      errors++;
      $display("FAIL first_valid: valid=%b busy=%b, need 1 1", obs_v, obs_b);
    end
    while (got < total && got < stop_at && cycles < 20000) begin
      if (stall) begin
        vectors++;
        if (obs_d !== pd || obs_l !== pl) begin
          errors++;
          $display("FAIL stall_hold@%0d: data=%h last=%b, need %h %b",
                   got, obs_d, obs_l, pd, pl);
        end
      end
      vectors++;
      if (obs_v !== 1'b1) begin
        errors++;
        $display("FAIL valid_gap@%0d: valid=%b, need 1", got, obs_v);
      end
      start = (got == s1 || got == s2);
      out_ready = ($urandom_range(99) < pct);
      if (out_ready) begin
        vectors++;
        if (obs_d !== ref_sample(got, rep) || obs_l !== (got == total - 1)) begin
          errors++;
          $display("FAIL sample@%0d: data=%h last=%b, need %h %b", got, obs_d,
                   obs_l, ref_sample(got, rep), got == total - 1);
        end
        if (obs_l === 1'b1) lasts++;
        got++;
      end
      stall = !out_ready;
      pd = obs_d;
      pl = obs_l;
      cycle();
      cycles++;
    end
    start = 1'b0;
    if (cycles >= 20000) begin
      vectors++;
      errors++;
      $display("FAIL timeout: %0d samples after %0d cycles", got, cycles);
    end
  endtask

  task automatic check_idle(input string name, input logic zero_data);
    vectors++;
    if (obs_v !== 1'b0 || obs_b !== 1'b0 || obs_l !== 1'b0 ||
        (zero_data && obs_d !== 32'h0)) begin
      errors++;
      $display("FAIL %s: valid=%b busy=%b last=%b data=%h, need 0 0 0 %s",
               name, obs_v, obs_b, obs_l, obs_d, zero_data ? "0" : "any");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; start = 1'b1; sel = 1'b0; out_ready = 1'b1;
    repeat (3) cycle();
    check_idle("reset_a", 1'b1);
    sel = 1'b1;
    #1;
    check_idle("reset_b", 1'b1);
    sel = 1'b0;
    rst = 1'b0; start = 1'b0;
    cycle();
    check_idle("reset_ignores_start", 1'b1);
  endtask

  task automatic test_nominal();
    int got, cyc, lasts;
    sel = 1'b0;
    stream(10, 100, 1 << 30, -1, -1, got, cyc, lasts);
    vectors++;
    if (got !== 320 || cyc !== 320 || lasts !== 1) begin
      errors++;
      $display("FAIL nominal_len: samples=%0d cycles=%0d lasts=%0d, need 320 320 1",
               got, cyc, lasts);
    end
    check_idle("nominal_end", 1'b0);
  endtask

  task automatic test_backpressure();
    int got, cyc, lasts;
    sel = 1'b0;
    stream(10, 50, 1 << 30, -1, -1, got, cyc, lasts);
    vectors++;
    if (got !== 320 || lasts !== 1) begin
      errors++;
      $display("FAIL bp_len: samples=%0d lasts=%0d, need 320 1", got, lasts);
    end
    check_idle("bp_end", 1'b0);
  endtask

  task automatic test_start_busy();
    int got, cyc, lasts;
    sel = 1'b0;
    stream(10, 100, 1 << 30, 50, 319, got, cyc, lasts);
    vectors++;
    if (got !== 320 || cyc !== 320 || lasts !== 1) begin
      errors++;
      $display("FAIL busy_start_len: samples=%0d cycles=%0d lasts=%0d, need 320 320 1",
               got, cyc, lasts);
    end
    check_idle("busy_start_end", 1'b0);
    cycle();
    check_idle("busy_start_no_second", 1'b0);
    cycle();
    stream(10, 100, 1 << 30, -1, -1, got, cyc, lasts);
    vectors++;
    if (got !== 320 || lasts !== 1) begin
      errors++;
      $display("FAIL second_frame: samples=%0d lasts=%0d, need 320 1", got, lasts);
    end
    check_idle("second_frame_end", 1'b0);
  endtask

  task automatic test_abort();
    int got, cyc, lasts;
    sel = 1'b0;
    stream(10, 100, 200, -1, -1, got, cyc, lasts);
    enable = 1'b0;
    cycle();
    check_idle("abort", 1'b1);
    enable = 1'b1;
    cycle();
    stream(10, 70, 1 << 30, -1, -1, got, cyc, lasts);
    vectors++;
    if (got !== 320 || lasts !== 1) begin
      errors++;
      $display("FAIL abort_restart: samples=%0d lasts=%0d, need 320 1", got, lasts);
    end
  endtask

  task automatic test_reset_mid();
    int got, cyc, lasts;
    sel = 1'b0;
    cycle();
    stream(10, 100, 100, -1, -1, got, cyc, lasts);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_idle("reset_mid", 1'b1);
    stream(10, 100, 1 << 30, -1, -1, got, cyc, lasts);
    vectors++;
    if (got !== 320 || cyc !== 320 || lasts !== 1) begin
      errors++;
      $display("FAIL reset_restart: samples=%0d cycles=%0d lasts=%0d, need 320 320 1",
               got, cyc, lasts);
    end
  endtask

  task automatic test_variant();
    int got, cyc, lasts;
    cycle();
    sel = 1'b1;
    stream(2, 100, 1 << 30, -1, -1, got, cyc, lasts);
    vectors++;
    if (got !== 192 || cyc !== 192 || lasts !== 1) begin
      errors++;
      $display("FAIL variant_len: samples=%0d cycles=%0d lasts=%0d, need 192 192 1",
               got, cyc, lasts);
    end
    check_idle("variant_end", 1'b0);
    sel = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; start = 1'b0; sel = 1'b0; out_ready = 1'b1;
    test_reset();
    test_nominal();
    test_backpressure();
    test_start_busy();
    test_abort();
    test_reset_mid();
    test_variant();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
